// File: rtl/core_sequencer_pkg.sv
// Shared constants and types for the core program sequencer.
package core_sequencer_pkg;

    // Filler word the core treats as a no-op.
    localparam logic [14:0] NOP = 15'h0028;

    // Program word field positions.
    localparam int unsigned CTRL_BIT    = 15;
    localparam int unsigned OP_MSB      = 14;
    localparam int unsigned OP_LSB      = 12;
    localparam int unsigned OPERAND_MSB = 11;
    localparam int unsigned OPERAND_LSB = 0;

    // Control-word opcodes; 3'b101..3'b111 are reserved.
    localparam logic [2:0] OP_HALT  = 3'b000;
    localparam logic [2:0] OP_JMP   = 3'b001;
    localparam logic [2:0] OP_LOOP  = 3'b010;
    localparam logic [2:0] OP_ENDL  = 3'b011;
    localparam logic [2:0] OP_WAITV = 3'b100;

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        RUN,
        WAIT_V
    } seq_state_e;

endpackage

// File: rtl/core_sequencer_if.sv
// Control, ROM and core-facing signals of the sequencer.
interface core_sequencer_if #(
    parameter int unsigned INSTRUCTION_WIDTH  = 15,
    parameter int unsigned PROG_ADDRESS_WIDTH = 10
);
    logic                          start;
    logic [PROG_ADDRESS_WIDTH-1:0] start_address;
    logic                          abort;
    logic [PROG_ADDRESS_WIDTH-1:0] prog_address;
    logic [15:0]                   prog_data;
    logic [INSTRUCTION_WIDTH-1:0]  instruction;
    logic                          issue;
    logic                          busy;
    logic                          done;

    // Sequencer side.
    modport master (
        input  start, start_address, abort, prog_data,
        output prog_address, instruction, issue, busy, done
    );

    // Controller / ROM / core side.
    modport slave (
        output start, start_address, abort, prog_data,
        input  prog_address, instruction, issue, busy, done
    );
endinterface

// File: rtl/vsync_sync.sv
// Two-flop synchroniser for the asynchronous vsync, followed by a
// rising-edge detector producing a one-cycle pulse.
module vsync_sync (
    input  logic clk,
    input  logic reset,
    input  logic vsync,
    output logic rise
);
    logic meta;
    logic sync;
    logic prev;

    // Synchronise vsync and keep one delayed copy for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= 1'b0;
            sync <= 1'b0;
            prev <= 1'b0;
        end else begin
            meta <= vsync;
            sync <= meta;
            prev <= sync;
        end
    end

    assign rise = sync & ~prev;
endmodule

// File: rtl/core_sequencer.sv
// Program sequencer: fetches one word per cycle from a synchronous ROM,
// issues core words and executes JMP/LOOP/ENDL/WAITV/HALT control words.
module core_sequencer
    import core_sequencer_pkg::*;
#(
    parameter int unsigned INSTRUCTION_WIDTH  = 15,
    parameter int unsigned PROG_ADDRESS_WIDTH = 10,
    parameter int unsigned LOOP_WIDTH         = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             vsync,
    core_sequencer_if.master bus
);
    localparam logic [INSTRUCTION_WIDTH-1:0]  NOP_WORD = INSTRUCTION_WIDTH'(NOP);
    localparam logic [PROG_ADDRESS_WIDTH-1:0] ADDR_ONE = PROG_ADDRESS_WIDTH'(1);
    localparam logic [LOOP_WIDTH-1:0]         LOOP_ONE = LOOP_WIDTH'(1);

    seq_state_e                    state;
    logic [PROG_ADDRESS_WIDTH-1:0] data_addr;    // address of the word on prog_data
    logic                          data_valid;   // prog_data holds a word to execute
    logic                          halt_pending;
    logic [LOOP_WIDTH-1:0]         loop_count;
    logic [PROG_ADDRESS_WIDTH-1:0] loop_start;
    logic                          vsync_rise;

    logic                          is_ctrl;
    logic [2:0]                    op;
    logic [11:0]                   operand;
    logic [LOOP_WIDTH-1:0]         loop_init;

    assign is_ctrl   = bus.prog_data[CTRL_BIT];
    assign op        = bus.prog_data[OP_MSB:OP_LSB];
    assign operand   = bus.prog_data[OPERAND_MSB:OPERAND_LSB];
    assign loop_init = (operand == '0) ? LOOP_ONE : LOOP_WIDTH'(operand);

    vsync_sync u_vsync_sync (
        .clk   (clk),
        .reset (reset),
        .vsync (vsync),
        .rise  (vsync_rise)
    );

    // Sequencer FSM: fetch, decode and registered core-facing outputs.
    // A taken branch clears data_valid so the word already in flight is
    // replaced by a NOP; done is delayed one cycle behind the HALT slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            bus.prog_address <= '0;
            bus.instruction  <= NOP_WORD;
            bus.issue        <= 1'b0;
            bus.busy         <= 1'b0;
            bus.done         <= 1'b0;
            data_addr        <= '0;
            data_valid       <= 1'b0;
            halt_pending     <= 1'b0;
            loop_count       <= '0;
            loop_start       <= '0;
        end else begin
            bus.instruction <= NOP_WORD;
            bus.issue       <= 1'b0;
            bus.done        <= halt_pending;
            halt_pending    <= 1'b0;
            data_valid      <= 1'b0;
            if (bus.abort) begin
                state    <= IDLE;
                bus.busy <= 1'b0;
                bus.done <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.start) begin
                            state            <= PRIME;
                            bus.busy         <= 1'b1;
                            bus.prog_address <= bus.start_address;
                        end
                    end
                    PRIME: begin
                        state            <= RUN;
                        bus.prog_address <= bus.prog_address + ADDR_ONE;
                        data_addr        <= bus.prog_address;
                        data_valid       <= 1'b1;
                    end
                    RUN: begin
                        bus.prog_address <= bus.prog_address + ADDR_ONE;
                        data_addr        <= bus.prog_address;
                        data_valid       <= 1'b1;
                        if (data_valid) begin
                            if (!is_ctrl) begin
                                bus.instruction <= INSTRUCTION_WIDTH'(bus.prog_data[CTRL_BIT-1:0]);
                                bus.issue       <= 1'b1;
                            end else begin
                                case (op)
                                    OP_HALT: begin
                                        state        <= IDLE;
                                        bus.busy     <= 1'b0;
                                        halt_pending <= 1'b1;
                                    end
                                    OP_JMP: begin
                                        bus.prog_address <= operand[PROG_ADDRESS_WIDTH-1:0];
                                        data_valid       <= 1'b0;
                                    end
                                    OP_LOOP: begin
                                        loop_count <= loop_init;
                                        loop_start <= data_addr + ADDR_ONE;
                                    end
                                    OP_ENDL: begin
                                        if (loop_count > LOOP_ONE) begin
                                            loop_count       <= loop_count - LOOP_ONE;
                                            bus.prog_address <= loop_start;
                                            data_valid       <= 1'b0;
                                        end else begin
                                            loop_count <= '0;
                                        end
                                    end
                                    OP_WAITV: begin
                                        state            <= WAIT_V;
                                        bus.prog_address <= data_addr + ADDR_ONE;
                                    end
                                    default: ;
                                endcase
                            end
                        end
                    end
                    WAIT_V: begin
                        if (vsync_rise) begin
                            state <= PRIME;
                        end
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_core_sequencer.sv
// Directed self-checking bench for core_sequencer with a synchronous ROM model.
module tb_core_sequencer;
    localparam logic [14:0] NOP_W = 15'h0028;
    localparam logic [15:0] HALT  = 16'h8000;

    logic clk;
    logic reset;
    logic vsync;
    logic [15:0] rom [0:1023];

    int n_checks;
    int n_errors;
    int issue_cyc[$];
    logic [14:0] issue_word[$];
    int done_cyc;

    core_sequencer_if #(.INSTRUCTION_WIDTH(15), .PROG_ADDRESS_WIDTH(10)) bus ();

    core_sequencer #(
        .INSTRUCTION_WIDTH  (15),
        .PROG_ADDRESS_WIDTH (10),
        .LOOP_WIDTH         (12)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .vsync (vsync),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous program ROM.
    always @(posedge clk) bus.prog_data <= rom[bus.prog_address];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_rom();
        for (int i = 0; i < 1024; i++) rom[i] = HALT;
    endtask

    function automatic int cyc_at(input int i);
        return (i < issue_cyc.size()) ? issue_cyc[i] : -1;
    endfunction

    function automatic logic [14:0] word_at(input int i);
        return (i < issue_word.size()) ? issue_word[i] : 15'h7fff;
    endfunction

    // Pulse start, then record issued words until done or the cycle budget runs out.
    task automatic run_prog(input logic [9:0] addr, input int max_cyc);
        issue_cyc.delete();
        issue_word.delete();
        done_cyc = -1;
        bus.start = 1'b1;
        bus.start_address = addr;
        tick();
        bus.start = 1'b0;
        for (int c = 1; c <= max_cyc; c++) begin
            tick();
            if (bus.issue) begin
                issue_cyc.push_back(c);
                issue_word.push_back(bus.instruction);
            end
            if (bus.done) begin
                done_cyc = c;
                break;
            end
        end
    endtask

    initial begin
        int bad;
        int lat;
        logic [14:0] first_word;
        logic got_done;

        n_checks = 0;
        n_errors = 0;
        reset = 1'b1;
        vsync = 1'b0;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.start_address = '0;
        fill_rom();
        repeat (3) tick();

        check("rst_instr", bus.instruction, NOP_W);
        check("rst_issue", bus.issue, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_addr", bus.prog_address, 0);
        reset = 1'b0;
        tick();

        // Straight-line program then HALT.
        rom[0] = 16'h0C01; rom[1] = 16'h4C01; rom[2] = HALT;
        run_prog(10'd0, 20);
        check("lin_n_issue", issue_cyc.size(), 2);
        check("lin_cyc0", cyc_at(0), 2);
        check("lin_word0", word_at(0), 15'h0C01);
        check("lin_cyc1", cyc_at(1), 3);
        check("lin_word1", word_at(1), 15'h4C01);
        check("lin_done_cyc", done_cyc, 5);
        check("lin_busy_at_done", bus.busy, 0);
        check("lin_instr_at_done", bus.instruction, NOP_W);
        tick();
        check("lin_done_1cyc", bus.done, 0);
        check("lin_busy_after", bus.busy, 0);

        // LOOP 3 around one core word.
        fill_rom();
        rom[0] = 16'hA003; rom[1] = 16'h0C01; rom[2] = 16'hB000; rom[3] = HALT;
        run_prog(10'd0, 30);
        check("loop_n_issue", issue_cyc.size(), 3);
        check("loop_cyc0", cyc_at(0), 3);
        check("loop_cyc1", cyc_at(1), 6);
        check("loop_cyc2", cyc_at(2), 9);
        check("loop_word2", word_at(2), 15'h0C01);
        check("loop_done_cyc", done_cyc, 12);

        // LOOP 0 runs the body once.
        fill_rom();
        rom[0] = 16'hA000; rom[1] = 16'h0C01; rom[2] = 16'hB000; rom[3] = HALT;
        run_prog(10'd0, 20);
        check("loop0_n_issue", issue_cyc.size(), 1);
        check("loop0_done_cyc", done_cyc, 6);

        // JMP squashes the in-flight word.
        fill_rom();
        rom[5] = 16'h9010; rom[6] = 16'h0C77; rom[16] = 16'h0029; rom[17] = HALT;
        run_prog(10'd5, 20);
        check("jmp_n_issue", issue_cyc.size(), 1);
        check("jmp_cyc0", cyc_at(0), 4);
        check("jmp_word0", word_at(0), 15'h0029);
        check("jmp_done_cyc", done_cyc, 6);

        // Reserved opcode is a single NOP slot.
        fill_rom();
        rom[0] = 16'h0C01; rom[1] = 16'hF123; rom[2] = 16'h0C02; rom[3] = HALT;
        run_prog(10'd0, 20);
        check("rsv_n_issue", issue_cyc.size(), 2);
        check("rsv_cyc1", cyc_at(1), 4);
        check("rsv_word1", word_at(1), 15'h0C02);
        check("rsv_done_cyc", done_cyc, 6);

        // WAITV: early vsync ignored, start while busy ignored, resume on rise.
        fill_rom();
        rom[0] = 16'hC000; rom[1] = 16'h0C05; rom[2] = HALT; rom[16] = 16'h0C10;
        vsync = 1'b1;
        repeat (4) tick();
        vsync = 1'b0;
        repeat (4) tick();
        bus.start = 1'b1;
        bus.start_address = 10'd0;
        tick();
        bus.start = 1'b0;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            if (i == 20) begin
                bus.start = 1'b1;
                bus.start_address = 10'd16;
            end
            tick();
            bus.start = 1'b0;
            if (bus.issue || bus.instruction !== NOP_W || !bus.busy) bad++;
        end
        check("waitv_idle_slots", bad, 0);
        vsync = 1'b1;
        lat = -1;
        first_word = '0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (bus.issue) begin
                lat = c;
                first_word = bus.instruction;
                break;
            end
        end
        check("waitv_latency_ok", (lat >= 4 && lat <= 6), 1);
        check("waitv_word", first_word, 15'h0C05);
        got_done = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (bus.done) begin
                got_done = 1'b1;
                break;
            end
        end
        check("waitv_done", got_done, 1);
        vsync = 1'b0;
        repeat (4) tick();

        // Abort beats start while idle.
        bus.start = 1'b1;
        bus.abort = 1'b1;
        bus.start_address = 10'd0;
        tick();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        check("abort_vs_start_busy", bus.busy, 0);

        // Abort on the same edge as a JMP.
        fill_rom();
        rom[0] = 16'h0C01; rom[1] = 16'h9010; rom[2] = 16'h0C02; rom[16] = 16'h0C10;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        check("abort_pre_word", bus.instruction, 15'h0C01);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("abort_busy", bus.busy, 0);
        check("abort_instr", bus.instruction, NOP_W);
        check("abort_done", bus.done, 0);
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.issue || bus.busy || bus.done) bad++;
        end
        check("abort_quiet", bad, 0);

        // Asynchronous reset mid-loop.
        fill_rom();
        rom[0] = 16'hA005; rom[1] = 16'h0C01; rom[2] = 16'hB000; rom[3] = HALT;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (6) tick();
        #2 reset = 1'b1;
        #1;
        check("rst_mid_busy", bus.busy, 0);
        check("rst_mid_instr", bus.instruction, NOP_W);
        check("rst_mid_addr", bus.prog_address, 0);
        #2 reset = 1'b0;
        tick();
        // Stale loop count would make this ENDL jump back.
        fill_rom();
        rom[0] = 16'h0C01; rom[1] = 16'hB000; rom[2] = 16'h0C02; rom[3] = HALT;
        run_prog(10'd0, 20);
        check("rst_loop_n_issue", issue_cyc.size(), 2);
        check("rst_loop_word1", word_at(1), 15'h0C02);
        check("rst_loop_done_cyc", done_cyc, 6);

        // pc wraps from the top of the ROM to 0.
        fill_rom();
        rom[1022] = 16'h0C0A; rom[1023] = 16'h0C0B; rom[0] = HALT;
        run_prog(10'd1022, 20);
        check("wrap_n_issue", issue_cyc.size(), 2);
        check("wrap_word1", word_at(1), 15'h0C0B);
        check("wrap_done_cyc", done_cyc, 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/core_sequencer.md
# core_sequencer

Program sequencer for a `core` instance. Each cycle it fetches one 16-bit program word from a synchronous program ROM. Core words go to the core's `instruction` input; sequencer control words (JMP, LOOP/ENDL, WAITV, HALT) supply the branching and frame synchronisation the core lacks. The core executes `instruction` on every `clk` edge, so whenever no real instruction is issued the sequencer drives the no-op word.

## Interface
Parameters:
- `INSTRUCTION_WIDTH`, 15, core instruction width.
- `PROG_ADDRESS_WIDTH`, 10, program ROM address width.
- `LOOP_WIDTH`, 12, loop counter width.

Ports:
- `clk`  in  1  single clock, shared with `core`.
- `reset`  in  1  asynchronous, active-high.
- `start`  in  1  pulse; begin execution at `start_address`.
- `start_address`  in  PROG_ADDRESS_WIDTH  entry point.
- `abort`  in  1  pulse; stop immediately.
- `vsync`  in  1  frame sync from the `clk_buffer` domain (asynchronous).
- `prog_address`  out  PROG_ADDRESS_WIDTH  ROM address (registered).
- `prog_data`  in  16  ROM word for the address presented one edge earlier.
- `instruction`  out  INSTRUCTION_WIDTH  to `core.instruction` (registered).
- `issue`  out  1  high when `instruction` carries a program word, not a filler NOP.
- `busy`  out  1  high in all states except IDLE.
- `done`  out  1  one-cycle pulse on HALT.

## Operation
- NOP = 15'h0028 (bit0=0, op[5:1]=5'b10100). The core ignores it.
- Program word with bit15=0: bits[14:0] are issued to the core unchanged.
- Program word with bit15=1 is a control word. Opcode is [14:12]; operand is [11:0].
  - 000 HALT: enter IDLE and pulse `done`.
  - 001 JMP: pc ← operand[PROG_ADDRESS_WIDTH-1:0].
  - 010 LOOP: loop_count ← operand, loop_start ← addr+1. An operand of 0 behaves as 1.
  - 011 ENDL: if loop_count>1, decrement loop_count and jump to loop_start. Otherwise set loop_count ← 0 and fall through.
  - 100 WAITV: enter WAIT_V.
  - 101–111: reserved. Consumed as a NOP with no side effect.
- Loop nesting is one level deep. A LOOP inside a loop overwrites the counter. ENDL with no open loop falls through.
- Every control word occupies one NOP issue slot (`issue`=0).
- The ROM word already in flight after a taken JMP/ENDL, HALT or WAITV is squashed and replaced by a NOP.
- The pc wraps from 2^PROG_ADDRESS_WIDTH−1 to 0.
- States:
  - IDLE → PRIME on `start`.
  - PRIME → RUN after one cycle.
  - RUN → WAIT_V on WAITV.
  - RUN → IDLE on HALT.
  - WAIT_V → PRIME on a synchronised `vsync` rising edge; resume at WAITV address + 1.
  - Any state → IDLE on `abort`. `abort` has priority over `start` and over any decoded word.
- `start` while busy is ignored.
- `vsync` passes through a 2-flop synchroniser, then a rising-edge detector. Edges that arrive outside WAIT_V are not remembered.
- Reset values:
  - State IDLE.
  - `instruction`=NOP, `issue`=0, `busy`=0, `done`=0.
  - `prog_address`=0.
  - loop_count=0, loop_start=0.
  - Synchroniser flops 0.

## Timing
- `start` sampled at edge E0 → `prog_address`=S after E0.
- ROM word S is visible after E1.
- `instruction`=word(S) with `issue`=1 after E2. Start-to-first-issue latency is 2 cycles.
- Sustained throughput is 1 instruction per cycle.
- Taken JMP/ENDL: 2 NOP slots (the control word and the squashed word), then the target word.
- Not-taken ENDL, LOOP and reserved words: 1 NOP slot.
- WAITV resume: the synchronised edge is detected about 3 cycles after the raw `vsync` edge. The first resumed issue follows 2 cycles after detection.
- HALT: `done`=1 for exactly the cycle after the HALT edge. `busy`=0 in that same cycle. `instruction`=NOP from then on.
- `abort`: `instruction`=NOP and `busy`=0 from the next edge. `done` is not pulsed.

## Structure
- Package `core_sequencer_pkg`:
  - NOP constant.
  - Control-word opcode constants (HALT, JMP, LOOP, ENDL, WAITV).
  - State enum (IDLE, PRIME, RUN, WAIT_V).
  - Bit-position constants for the control flag and operand fields.
- Sub-module `vsync_sync`: 2-flop synchroniser plus rising-edge pulse. It takes the same `clk` and `reset`.

## Test plan
- ROM[0..2] = 16'h0C01, 16'h4C01, 16'h8000 (two core words, then HALT); start_address=0, `start` → `instruction` sequence 0x0C01, 0x4C01 with `issue`=1 at cycles 2–3; NOP at cycle 4; `done` pulse at cycle 5; `busy`=0 afterwards.
- ROM[0]=16'hA003 (LOOP 3), ROM[1]=16'h0C01, ROM[2]=16'hB000 (ENDL), ROM[3]=HALT → 0x0C01 issued exactly 3 times, with 2 NOP slots before each repeat; `done` follows.
- ROM[5]=16'h9010 (JMP 0x010), ROM[0x10]=16'h0029, start_address=5 → `instruction` = NOP, NOP, then 0x0029; word 6 is never issued.
- WAITV at address 0, `vsync` held low for 50 cycles, then raised → NOP with `issue`=0 throughout the wait; word 1 issued 4–6 cycles after the `vsync` rise. A `vsync` pulse before the WAITV is reached is ignored.
- `abort` during RUN at the same edge as a JMP; later `start` while busy; `reset` asserted mid-loop → abort wins and no jump occurs; the later `start` is ignored while busy; on `reset`, outputs immediately show the reset values and loop_count=0.
- Program ending at address 2^PROG_ADDRESS_WIDTH−1 followed by ROM[0]=HALT → pc wraps to 0 and the run halts normally.
